// File: rtl/uart_tx_fifo.sv
// Console byte sink: buffers incoming characters in a circular FIFO and
// shifts them out as 8N1 UART frames on tx, back-to-back while data remains.
module uart_tx_fifo #(
  parameter int IN_W         = 11,
  parameter int DEPTH        = 16,
  parameter int CLKS_PER_BIT = 868
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic [IN_W-1:0]          in_byte,
  input  logic                     in_byte_en,
  output logic                     tx,
  output logic                     busy,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   fifo_count,
  output logic                     overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int BW = $clog2(CLKS_PER_BIT);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t          state;
  logic [7:0]      mem [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [7:0]      shift;
  logic [2:0]      bit_idx;
  logic [BW-1:0]   baud_cnt;
  logic [CW-1:0]   next_count;
  logic            baud_last;
  logic            not_empty;
  logic            push;
  logic            pop;
  logic            next_idle;
  logic            unused_upper;

  assign unused_upper = ^in_byte[IN_W-1:8];

  assign full      = (fifo_count == CW'(DEPTH));
  assign not_empty = (fifo_count != '0);
  assign baud_last = (baud_cnt == BW'(CLKS_PER_BIT - 1));
  assign push      = in_byte_en && !full;
  assign pop       = not_empty && ((state == IDLE) || (state == STOP && baud_last));
  // The FSM only rests in IDLE when nothing is queued at the point it would leave STOP/IDLE.
  assign next_idle = !not_empty && ((state == IDLE) || (state == STOP && baud_last));

  always_comb begin
    next_count = fifo_count;
    case ({push, pop})
      2'b10:   next_count = fifo_count + 1'b1;
      2'b01:   next_count = fifo_count - 1'b1;
      default: next_count = fifo_count;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= in_byte[7:0];
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
      overflow   <= 1'b0;
      busy       <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      fifo_count <= next_count;
      if (in_byte_en && full) overflow <= 1'b1;
      busy <= !next_idle || (next_count != '0);
    end
  end

  // Shift register is consumed LSB first; tx is always loaded one bit ahead.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state    <= IDLE;
      tx       <= 1'b1;
      shift    <= '0;
      bit_idx  <= '0;
      baud_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          tx <= 1'b1;
          if (not_empty) begin
            shift    <= mem[rd_ptr];
            tx       <= 1'b0;
            baud_cnt <= '0;
            state    <= START;
          end
        end
        START: begin
          if (baud_last) begin
            baud_cnt <= '0;
            tx       <= shift[0];
            bit_idx  <= '0;
            state    <= DATA;
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        DATA: begin
          if (baud_last) begin
            baud_cnt <= '0;
            if (bit_idx == 3'd7) begin
              tx    <= 1'b1;
              state <= STOP;
            end else begin
              bit_idx <= bit_idx + 1'b1;
              shift   <= {1'b0, shift[7:1]};
              tx      <= shift[1];
            end
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        STOP: begin
          if (baud_last) begin
            baud_cnt <= '0;
            if (not_empty) begin
              shift <= mem[rd_ptr];
              tx    <= 1'b0;
              state <= START;
            end else begin
              state <= IDLE;
            end
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          tx    <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Scoreboard bench for uart_tx_fifo: stimulus queues expected bytes, a UART
// monitor decodes tx frames and compares them against the queue.
module tb_uart_tx_fifo;

  localparam int IN_W  = 11;
  localparam int DEPTH = 16;
  localparam int CPB   = 4;

  logic            clk = 1'b0;
  logic            resetn = 1'b0;
  logic [IN_W-1:0] in_byte = '0;
  logic            in_byte_en = 1'b0;
  logic            tx;
  logic            busy;
  logic            full;
  logic [4:0]      fifo_count;
  logic            overflow;

  int         checks = 0;
  int         errors = 0;
  logic [7:0] exp_q[$];

  uart_tx_fifo #(
    .IN_W(IN_W),
    .DEPTH(DEPTH),
    .CLKS_PER_BIT(CPB)
  ) dut (
    .clk(clk),
    .resetn(resetn),
    .in_byte(in_byte),
    .in_byte_en(in_byte_en),
    .tx(tx),
    .busy(busy),
    .full(full),
    .fifo_count(fifo_count),
    .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
    end
  endtask

  // Called at a negedge; the write lands on the following posedge.
  task automatic applyStimulus(input logic [IN_W-1:0] data, input bit accept);
    in_byte    = data;
    in_byte_en = 1'b1;
    if (accept) exp_q.push_back(data[7:0]);
    @(negedge clk);
    in_byte_en = 1'b0;
  endtask

  task automatic waitDrain(input string name, input int budget);
    int n = 0;
    while ((exp_q.size() != 0 || busy !== 1'b0) && n < budget) begin
      @(negedge clk);
      n++;
    end
    checkOutput({name, "_pending"}, exp_q.size(), 0);
    checkOutput({name, "_busy"}, busy, 0);
  endtask

  task automatic waitSample(input int n, inout bit aborted);
    repeat (n) begin
      @(negedge clk);
      if (resetn !== 1'b1) aborted = 1'b1;
    end
  endtask

  // Entered half a cycle into the start bit; samples every bit at its middle.
  task automatic decodeFrame();
    bit         aborted = 1'b0;
    logic [7:0] data;
    logic       start_bit;
    logic       stop_bit;
    waitSample(CPB / 2, aborted);
    start_bit = tx;
    for (int i = 0; i < 8; i++) begin
      waitSample(CPB, aborted);
      data[i] = tx;
    end
    waitSample(CPB, aborted);
    stop_bit = tx;
    if (aborted) begin
      $display("[TB] frame abandoned by reset");
      return;
    end
    checkOutput("start_bit", start_bit, 0);
    checkOutput("stop_bit", stop_bit, 1);
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL unexpected_frame: got %02h expected none", data);
    end else begin
      checkOutput("frame_data", data, exp_q.pop_front());
    end
  endtask

  initial begin : monitor
    forever begin
      @(negedge clk);
      if (resetn === 1'b1 && tx === 1'b0) decodeFrame();
    end
  end

  initial begin : stimulus
    int n;
    int low;

    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      in_byte_en = ~in_byte_en;
      in_byte    = IN_W'(i * 37);
      checkOutput("reset_hold", 32'({tx, busy, full, overflow, fifo_count}), 32'h100);
    end
    @(negedge clk);
    in_byte_en = 1'b0;
    resetn     = 1'b1;
    repeat (3) @(negedge clk);
    checkOutput("post_reset_idle", 32'({tx, busy, fifo_count}), 32'h40);

    $display("[TB] single byte 0x41");
    applyStimulus(11'h041, 1'b1);
    checkOutput("write_count", fifo_count, 1);
    checkOutput("write_tx_idle", tx, 1);
    checkOutput("write_busy", busy, 1);
    @(negedge clk);
    checkOutput("start_latency", tx, 0);
    checkOutput("pop_count", fifo_count, 0);
    repeat (39) @(negedge clk);
    checkOutput("busy_last_stop", busy, 1);
    checkOutput("tx_stop", tx, 1);
    @(negedge clk);
    checkOutput("busy_drop", busy, 0);
    waitDrain("single", 20);

    $display("[TB] upper bits ignored");
    applyStimulus(11'h7A5, 1'b1);
    waitDrain("upper", 100);

    $display("[TB] back-to-back Hi\\n");
    applyStimulus(11'h048, 1'b1);
    applyStimulus(11'h069, 1'b1);
    applyStimulus(11'h00A, 1'b1);
    checkOutput("peak_count", fifo_count, 2);
    n = 0;
    while (busy === 1'b1 && n < 300) begin
      @(negedge clk);
      n++;
    end
    checkOutput("stream_len", n, 119);
    waitDrain("stream", 20);

    $display("[TB] overflow with 20 writes");
    for (int i = 0; i < 20; i++) begin
      applyStimulus(IN_W'(8'h30 + i), (i < 17));
      if (i == 16) begin
        checkOutput("fill_count", fifo_count, 16);
        checkOutput("fill_full", full, 1);
        checkOutput("fill_overflow", overflow, 0);
      end
    end
    checkOutput("ovf_count", fifo_count, 16);
    checkOutput("ovf_full", full, 1);
    checkOutput("ovf_flag", overflow, 1);
    waitDrain("overflow", 1000);
    checkOutput("overflow_sticky", overflow, 1);
    checkOutput("drained_full", full, 0);

    $display("[TB] reset during data bit 3");
    applyStimulus(11'h05A, 1'b1);
    repeat (19) @(negedge clk);
    checkOutput("pre_reset_busy", busy, 1);
    checkOutput("pre_reset_bit3", tx, 1);
    resetn = 1'b0;
    exp_q.delete();
    @(negedge clk);
    checkOutput("reset_tx", tx, 1);
    checkOutput("reset_count", fifo_count, 0);
    checkOutput("reset_busy", busy, 0);
    checkOutput("reset_overflow", overflow, 0);
    repeat (3) @(negedge clk);
    resetn = 1'b1;
    low = 0;
    repeat (60) begin
      @(negedge clk);
      if (tx !== 1'b1) low++;
    end
    checkOutput("no_resume", low, 0);
    applyStimulus(11'h0C3, 1'b1);
    waitDrain("after_reset", 100);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/uart_tx_fifo.md
Name: uart_tx_fifo

Overview:
- Downstream consumer of the SoC's console byte stream (out_byte / out_byte_en).
- Buffers each written character in a small FIFO and serializes it as 8N1 UART on a single tx pin.
- Lets the system drive a real serial line or a bench-side UART monitor instead of the simulation-only $write path.
- Sits between the system top and the board pin.

Parameters:
- IN_W, 11, width of the incoming byte bus; only bits [7:0] are transmitted.
- DEPTH, 16, FIFO entries; power of two, minimum 2.
- CLKS_PER_BIT, 868, clk cycles per UART bit (100 MHz / 115200); minimum 2.

Ports:
- clk  in  1  system clock.
- resetn  in  1  synchronous active-low reset.
- in_byte  in  IN_W  character from the system; bits [IN_W-1:8] ignored.
- in_byte_en  in  1  one-cycle write strobe; in_byte sampled on that clk edge.
- tx  out  1  UART serial line; idles high.
- busy  out  1  high while the FIFO is non-empty or a frame is in progress.
- full  out  1  FIFO holds DEPTH entries.
- fifo_count  out  $clog2(DEPTH)+1  current FIFO occupancy.
- overflow  out  1  sticky; set when a write is dropped.

Behaviour:
- Reset: clock clk; resetn is synchronous, active-low. While resetn=0 on a clk edge:
  - tx=1, busy=0, full=0, fifo_count=0, overflow=0.
  - FSM enters IDLE; FIFO pointers, bit counter and baud counter are cleared.
  - Reset mid-frame aborts the frame immediately; tx returns high on that edge.
- FIFO:
  - Circular buffer; read/write pointers wrap modulo DEPTH.
  - Write when in_byte_en=1 and not full: store in_byte[7:0]; fifo_count increments on that edge.
  - Write when full: data dropped; overflow<=1 (cleared only by reset); count unchanged.
  - Write and pop on the same edge: count unchanged; both pointers advance.
  - Writing while full while a pop happens on the same edge is still a drop (full is evaluated before the edge).
- FSM states: IDLE, START, DATA, STOP.
  - IDLE: tx=1. If fifo_count!=0: pop head into shift register, tx<=0, baud counter<=0, go START.
  - START: hold tx=0 for CLKS_PER_BIT cycles. On the last cycle: tx<=shift[0], bit index<=0, go DATA.
  - DATA: each bit held CLKS_PER_BIT cycles, LSB first. After bit 7 completes: tx<=1, go STOP.
  - STOP: hold tx=1 for CLKS_PER_BIT cycles. On completion:
    - FIFO non-empty: pop, tx<=0, go START (back-to-back, no idle gap).
    - Otherwise: go IDLE.
- Latency: a write on edge N into an empty, idle block makes tx fall after edge N+1.
- Frame length: exactly 10*CLKS_PER_BIT cycles, start edge to next start edge, when streaming.
- Outputs:
  - busy = (state!=IDLE) | (fifo_count!=0), registered.
  - full = (fifo_count==DEPTH).
  - tx is a registered output (glitch-free).
- Baud counter is compared against CLKS_PER_BIT-1; no fractional divide.

Test Plan:
- Reset hold: resetn=0 for 100 cycles with in_byte_en toggling -> tx=1, busy=0, fifo_count=0, overflow=0 throughout.
- Single byte: CLKS_PER_BIT=4, write 0x41 -> tx low one cycle after the write edge; bit stream 0,1,0,0,0,0,0,1,0,1, each 4 cycles. busy drops after 40 cycles.
- Upper bits ignored: write 11'h7A5 -> frame carries 0xA5; monitor decodes 0xA5.
- Back-to-back: write "Hi\n" on 3 consecutive cycles -> fifo_count peaks at 2, three frames with no idle gap (120 cycles at CLKS_PER_BIT=4), decoded 0x48, 0x69, 0x0A.
- Overflow: DEPTH=16, write 20 bytes on consecutive cycles -> first pops immediately, FIFO fills to 16 and full=1. Later writes are dropped, overflow=1 stays set. The 17 accepted bytes are transmitted in order.
- Reset mid-frame: assert resetn=0 during DATA bit 3 -> tx=1 on the next edge, FIFO empty, no partial frame resumes after release; a fresh write afterwards transmits cleanly.
